// File: rtl/tbird_turn_scheduler.sv
// Tail-light turn scheduler: synchronizes and debounces three raw active-low
// buttons, arbitrates left/right/hazard requests, generates the lamp step
// timebase and drives the mode/phase pair consumed by the lamp datapath.
// Optional lamp decoder outputs are enabled by defining TBIRD_LAMP_DECODE_EN.
module tbird_turn_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_DIV        = 5000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       right_button,
  input  logic       left_button,
  input  logic       hazard_button,
  output logic [1:0] mode,
  output logic [1:0] phase,
  output logic       step_tick,
  output logic       seq_done,
  output logic       busy
`ifdef TBIRD_LAMP_DECODE_EN
  ,
  output logic [2:0] left_lamps,
  output logic [2:0] right_lamps
`endif
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PS_W = $clog2(STEP_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LEFT   = 2'b01,
    ST_RIGHT  = 2'b10,
    ST_HAZARD = 2'b11
  } state_t;

  // Bit 0 right, bit 1 left, bit 2 hazard.
  logic [2:0] raw_n;
  logic [2:0] btn_db;
  assign raw_n = {hazard_button, left_button, right_button};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            db_reg;
      logic [DB_W-1:0] cnt_reg;
      logic            level;

      // Synchronized button, converted to active-high.
      assign level = ~sync2_reg;

      // Two-flop synchronizer, parked at the released (high) level.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
        end else begin
          sync1_reg <= raw_n[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Debounce: flip only after the synced level has disagreed for DEBOUNCE_CYCLES cycles.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          db_reg  <= 1'b0;
          cnt_reg <= '0;
        end else if (level == db_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_LAST) begin
          db_reg  <= level;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end

      assign btn_db[gi] = db_reg;
    end
  endgenerate

  state_t          sel;
  state_t          state_reg, state_next;
  logic [1:0]      phase_reg, phase_next;
  logic [PS_W-1:0] count_reg, count_next;
  logic            step_tick_reg, step_tick_next;
  logic            seq_done_reg, seq_done_next;

  // First phase of a freshly entered sequence.
  function automatic logic [1:0] entry_phase(input state_t s);
    case (s)
      ST_HAZARD: entry_phase = 2'd3;
      ST_IDLE:   entry_phase = 2'd0;
      default:   entry_phase = 2'd1;
    endcase
  endfunction

  // Request arbitration; both turn buttons together count as hazard.
  always_comb begin
    sel = ST_IDLE;
    if (btn_db[2] || (btn_db[1] && btn_db[0])) sel = ST_HAZARD;
    else if (btn_db[1])                         sel = ST_LEFT;
    else if (btn_db[0])                         sel = ST_RIGHT;
  end

  // State, phase, prescaler and pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= 2'd0;
      count_reg     <= '0;
      step_tick_reg <= 1'b0;
      seq_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      count_reg     <= count_next;
      step_tick_reg <= step_tick_next;
      seq_done_reg  <= seq_done_next;
    end
  end

  // Next-state logic: switch only at the phase-0 boundary, except hazard pre-emption.
  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    seq_done_next = 1'b0;
    count_next    = (count_reg == PS_LAST) ? '0 : count_reg + PS_W'(1);
    case (state_reg)
      ST_IDLE: begin
        count_next = '0;
        if (sel != ST_IDLE) begin
          state_next = sel;
          phase_next = entry_phase(sel);
        end
      end
      default: begin
        if (state_reg != ST_HAZARD && sel == ST_HAZARD) begin
          state_next = ST_HAZARD;
          phase_next = 2'd3;
          count_next = '0;
        end else if (step_tick_reg) begin
          if (phase_reg == 2'd0) begin
            seq_done_next = 1'b1;
            state_next    = sel;
            phase_next    = entry_phase(sel);
            count_next    = '0;
          end else if (state_reg == ST_HAZARD) begin
            phase_next = 2'd0;
          end else begin
            phase_next = phase_reg + 2'd1;
          end
        end
      end
    endcase
    // Registered tick lines up with the last count of each step.
    step_tick_next = (state_next != ST_IDLE) && (count_next == PS_LAST);
  end

  assign mode      = state_reg;
  assign phase     = phase_reg;
  assign step_tick = step_tick_reg;
  assign seq_done  = seq_done_reg;
  assign busy      = (state_reg != ST_IDLE);

`ifdef TBIRD_LAMP_DECODE_EN
  logic [2:0] therm;

  // Lamp decode from registered mode/phase.
  always_comb begin
    case (phase_reg)
      2'd0:    therm = 3'b000;
      2'd1:    therm = 3'b001;
      2'd2:    therm = 3'b011;
      default: therm = 3'b111;
    endcase
    left_lamps  = 3'b000;
    right_lamps = 3'b000;
    case (state_reg)
      ST_LEFT:   left_lamps  = therm;
      ST_RIGHT:  right_lamps = therm;
      ST_HAZARD: begin
        if (phase_reg == 2'd3) begin
          left_lamps  = 3'b111;
          right_lamps = 3'b111;
        end
      end
      default: ;
    endcase
  end
`endif

endmodule
